// File: rtl/cpu_databus_pkg.sv
// Shared state encoding and default timing for the cpu_databus parallel bus master.
package cpu_databus_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        TURN   = 3'd4
    } bus_state_t;

    localparam int DEF_SETUP_CYC  = 2;
    localparam int DEF_STROBE_CYC = 4;
    localparam int DEF_HOLD_CYC   = 2;

    // Strobe cycles allowed while waiting for bus_ack before giving up.
    localparam logic [7:0] ACK_TIMEOUT = 8'd255;

    // The phase counter counts down to zero, so an N-cycle phase loads N-1.
    function automatic logic [3:0] phase_load(input int cycles);
        return 4'(cycles - 1);
    endfunction

endpackage

// File: rtl/cpu_databus_sync.sv
// Two-flop synchronizer for the asynchronous bus_ack input from the slave.
module cpu_databus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/cpu_databus_master.sv
// Initiator for the 16-bit asynchronous DSP-style parallel IO bus: one read/write per request.
// Optional macro CPU_DATABUS_ACK_EN adds slave bus_ack strobe extension with timeout and rsp_err.
module cpu_databus_master
    import cpu_databus_pkg::*;
#(
    parameter int BIT_W      = 16,
    parameter int ADDR_W     = 8,
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [BIT_W-1:0]  req_wdata,
    output logic              rsp_valid,
    output logic              rsp_wr,
    output logic [BIT_W-1:0]  rsp_rdata,
`ifdef CPU_DATABUS_ACK_EN
    output logic              rsp_err,
    input  logic              bus_ack,
`endif
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_ms_n,
    output logic              bus_rd_n,
    output logic              bus_wr_n,
    output logic [BIT_W-1:0]  bus_d_out,
    output logic              bus_d_oe,
    input  logic [BIT_W-1:0]  bus_d_in
);

    bus_state_t       state;
    logic [3:0]       phase_cnt;
    logic             lat_wr;
    logic [BIT_W-1:0] rd_buf;
    logic             strobe_done;

`ifdef CPU_DATABUS_ACK_EN
    logic       ack_sync;
    logic [7:0] tmo_cnt;
    logic       tmo_hit;
    logic       lat_err;

    cpu_databus_sync u_ack_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (bus_ack),
        .sync_out (ack_sync)
    );

    // Strobe runs its minimum length, then waits for ack unless the timeout fires first.
    assign tmo_hit     = (tmo_cnt == ACK_TIMEOUT - 8'd1);
    assign strobe_done = ((phase_cnt == 4'd0) && ack_sync) || tmo_hit;
`else
    assign strobe_done = (phase_cnt == 4'd0);
`endif

    assign req_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase_cnt <= 4'd0;
            lat_wr    <= 1'b0;
            rd_buf    <= '0;
            bus_addr  <= '0;
            bus_d_out <= '0;
            bus_ms_n  <= 1'b1;
            bus_rd_n  <= 1'b1;
            bus_wr_n  <= 1'b1;
            bus_d_oe  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_wr    <= 1'b0;
            rsp_rdata <= '0;
`ifdef CPU_DATABUS_ACK_EN
            tmo_cnt   <= 8'd0;
            lat_err   <= 1'b0;
            rsp_err   <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_wr    <= req_wr;
                        bus_addr  <= req_addr;
                        bus_d_out <= req_wdata;
                        bus_ms_n  <= 1'b0;
                        bus_d_oe  <= req_wr;
                        phase_cnt <= phase_load(SETUP_CYC);
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase_cnt == 4'd0) begin
                        bus_rd_n  <= lat_wr;
                        bus_wr_n  <= ~lat_wr;
                        phase_cnt <= phase_load(STROBE_CYC);
`ifdef CPU_DATABUS_ACK_EN
                        tmo_cnt   <= 8'd0;
`endif
                        state     <= STROBE;
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                STROBE: begin
                    // Read data is sampled on the closing edge while rd_n is still low.
                    if (strobe_done) begin
                        bus_rd_n  <= 1'b1;
                        bus_wr_n  <= 1'b1;
                        if (!lat_wr) begin
                            rd_buf <= bus_d_in;
                        end
`ifdef CPU_DATABUS_ACK_EN
                        lat_err   <= ~ack_sync;
`endif
                        phase_cnt <= phase_load(HOLD_CYC);
                        state     <= HOLD;
                    end else begin
                        if (phase_cnt != 4'd0) begin
                            phase_cnt <= phase_cnt - 4'd1;
                        end
`ifdef CPU_DATABUS_ACK_EN
                        tmo_cnt   <= tmo_cnt + 8'd1;
`endif
                    end
                end
                HOLD: begin
                    if (phase_cnt == 4'd0) begin
                        bus_ms_n  <= 1'b1;
                        bus_d_oe  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_wr    <= lat_wr;
                        if (!lat_wr) begin
                            rsp_rdata <= rd_buf;
                        end
`ifdef CPU_DATABUS_ACK_EN
                        rsp_err   <= lat_err;
`endif
                        state     <= TURN;
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
